// File: rtl/mul_pkg.sv
// Shared types for the M-extension multiplier pipeline.
// Optional output register is selected with MUL_OUT_REG_EN.
package mul_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef struct packed {
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              neg;
    logic [1:0]        op;
    logic              valid;
  } mul_stage_t;

endpackage

// File: rtl/mulu_stage.sv
// Combinational shift-add chunk: adds abs_a shifted for each
// set multiplier bit in [OFFSET +: B].
module mulu_stage
  import mul_pkg::*;
#(
  parameter int B      = 8,
  parameter int OFFSET = 0
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   abs_a,
  input  logic [XLEN-1:0]   abs_b,
  output logic [2*XLEN-1:0] acc_next
);

  logic [2*XLEN-1:0] sum;
  logic [2*XLEN-1:0] a_ext;

  always_comb begin
    a_ext = {{XLEN{1'b0}}, abs_a};
    sum   = acc;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= OFFSET && i < OFFSET + B && abs_b[i])
        sum = sum + (a_ext << i);
    end
    acc_next = sum;
  end

endmodule

// File: rtl/multiplier_pipeline.sv
// Fixed-latency pipelined MUL/MULH/MULHSU/MULHU with stall freeze.
// Define MUL_OUT_REG_EN to add a registered output (latency +1).
module multiplier_pipeline
  import mul_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            i_valid,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_multiplicand,
  input  logic [XLEN-1:0] i_multiplier,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int B = XLEN / STAGES;

  mul_stage_t        stq [STAGES];
  mul_stage_t        src [STAGES];
  logic [2*XLEN-1:0] nxt [STAGES];
  mul_stage_t        in_rec;
  mul_stage_t        last;
  logic              sign_a;
  logic              sign_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res;
  logic              unused_fields;

  always_comb begin
    sign_a = i_multiplicand[XLEN-1] &&
             (i_op == MUL_OP_MULH || i_op == MUL_OP_MULHSU);
    sign_b = i_multiplier[XLEN-1] && (i_op == MUL_OP_MULH);
    in_rec = '0;
    in_rec.abs_a = sign_a ? -i_multiplicand : i_multiplicand;
    in_rec.abs_b = sign_b ? -i_multiplier : i_multiplier;
    in_rec.neg   = sign_a ^ sign_b;
    in_rec.op    = i_op;
    in_rec.valid = i_valid;
  end

  always_comb begin
    src[0] = in_rec;
    for (int k = 1; k < STAGES; k++)
      src[k] = stq[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mulu_stage #(
      .B      (B),
      .OFFSET (k * B)
    ) u_chunk (
      .acc      (src[k].acc),
      .abs_a    (src[k].abs_a),
      .abs_b    (src[k].abs_b),
      .acc_next (nxt[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++)
        stq[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        stq[k]     <= src[k];
        stq[k].acc <= nxt[k];
      end
    end
  end

  assign last = stq[STAGES-1];
  assign unused_fields = ^{last.abs_a, last.abs_b};

  always_comb begin
    prod = last.neg ? -last.acc : last.acc;
    res  = (last.op == MUL_OP_MUL) ? prod[XLEN-1:0]
                                   : prod[2*XLEN-1:XLEN];
  end

`ifdef MUL_OUT_REG_EN
  logic            out_v;
  logic [XLEN-1:0] out_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_v <= 1'b0;
      out_r <= '0;
    end else if (!stall) begin
      out_v <= last.valid;
      out_r <= res;
    end
  end

  assign o_valid  = out_v;
  assign o_result = out_r;
`else
  assign o_valid  = last.valid;
  assign o_result = res;
`endif

endmodule

// File: tb/tb_multiplier_pipeline.sv
// Self-checking bench: constant vectors, corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_multiplier_pipeline;

  localparam int STAGES = 4;
`ifdef MUL_OUT_REG_EN
  localparam int LAT = STAGES + 1;
`else
  localparam int LAT = STAGES;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        i_valid;
  logic [1:0]  i_op;
  logic [31:0] i_multiplicand;
  logic [31:0] i_multiplier;
  logic        o_valid;
  logic [31:0] o_result;

  int checks = 0;
  int passed = 0;

  // Expected output stream: slot LAT-1 is what the outputs show now.
  logic        mv [LAT];
  logic [31:0] mr [LAT];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  multiplier_pipeline #(.STAGES(STAGES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .i_valid        (i_valid),
    .i_op           (i_op),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_valid        (o_valid),
    .o_result       (o_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [127:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{96{a[31]}}, a} : {96'b0, a};
    eb = (op == 2'b01) ? {{96{b[31]}}, b} : {96'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // One clock: apply inputs, advance the expected stream, compare.
  task automatic cyc(input string name, input logic v, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input logic st,
                     input logic rn);
    i_valid = v; i_op = op; i_multiplicand = a; i_multiplier = b;
    stall = st; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < LAT; i++) begin mv[i] = 1'b0; mr[i] = '0; end
    end else if (!st) begin
      for (int i = LAT - 1; i > 0; i--) begin
        mv[i] = mv[i-1]; mr[i] = mr[i-1];
      end
      mv[0] = v; mr[0] = exp;
    end
    #1;
    check({name, ".valid"}, {31'b0, o_valid}, {31'b0, mv[LAT-1]});
    if (mv[LAT-1]) check({name, ".result"}, o_result, mr[LAT-1]);
  endtask

  task automatic op_cyc(input string name, input logic v,
                        input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic st);
    cyc(name, v, op, a, b, ref_mul(op, a, b), st, 1'b1);
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++)
      cyc(name, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[5] = '{2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    vecs[6] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[7] = '{2'b00, 32'h00000000, 32'h12345678, 32'h00000000};

    for (int i = 0; i < LAT; i++) begin mv[i] = 1'b0; mr[i] = '0; end

    cyc("reset", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc("reset", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset.result", o_result, 32'h0);

    // Single op: exact latency from sampling edge.
    cyc("mul7", 1'b1, vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].exp,
        1'b0, 1'b1);
    idle("mul7", LAT + 1);

    // Constant table issued back-to-back.
    for (int i = 1; i < 8; i++)
      cyc($sformatf("vec%0d", i), 1'b1, vecs[i].op, vecs[i].a,
          vecs[i].b, vecs[i].exp, 1'b0, 1'b1);
    idle("vec_drain", LAT + 1);

    // Two ops in flight, 3-cycle stall.
    op_cyc("stall_a", 1'b1, 2'b01, 32'hDEADBEEF, 32'h12345678, 1'b0);
    op_cyc("stall_b", 1'b1, 2'b00, 32'h89ABCDEF, 32'hFEDCBA98, 1'b0);
    for (int i = 0; i < 3; i++)
      op_cyc("stall_hold", 1'b1, 2'b11, 32'hFFFF0000, 32'h1, 1'b1);
    idle("stall_drain", LAT + 1);

    // Reset with stall high discards three in-flight ops.
    op_cyc("rst_a", 1'b1, 2'b11, 32'hCAFEF00D, 32'h87654321, 1'b0);
    op_cyc("rst_b", 1'b1, 2'b10, 32'h80000001, 32'hFFFFFFFF, 1'b0);
    op_cyc("rst_c", 1'b1, 2'b00, 32'h00001234, 32'h00005678, 1'b0);
    cyc("rst_mid", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("rst_mid.result", o_result, 32'h0);
    idle("rst_quiet", 2 * STAGES);

    // Alternating valid.
    for (int i = 0; i < 16; i++)
      op_cyc("alt", logic'(i % 2 == 0), 2'($urandom_range(0, 3)),
             $urandom, $urandom, 1'b0);
    idle("alt_drain", LAT + 1);

    // Randomized traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: ;
      endcase
      op_cyc("rand", logic'($urandom_range(0, 3) != 0),
             2'($urandom_range(0, 3)), a, b,
             logic'($urandom_range(0, 4) == 0));
    end
    idle("rand_drain", LAT + 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
